osd_spi_master: RTL and testbench
=================================

// Module: osd_spi_master
// PURPOSE
//  Transmit end of the OSD SPI link: serialises command/data bytes from the
//  control CPU onto SPI_SCK/SPI_SS3/SPI_DI, which feed the video pipeline's OSD.
//  Mode 0 (SCK idle low, OSD samples on SCK rise), MSB first, SS3 active low.
//  A frame is a byte run ended by tx_last, e.g. cmd 0x20|line then 256 pixel bytes.
// PARAMETERS
//  CLK_DIV     4  SCK half-period in clk_sys cycles (>=1)
//  GAP_CYCLES  4  min clk_sys cycles SS3 stays high between frames (>=1)
// PORTS
//  clk_sys   in   1  master clock; all logic on rising edge
//  reset     in   1  asynchronous, active-high reset
//  tx_data   in   8  byte to send
//  tx_last   in   1  byte is last of frame; qualified by accept
//  tx_valid  in   1  tx_data/tx_last valid
//  tx_ready  out  1  block can take a byte this cycle
//  busy      out  1  frame in progress (state != IDLE)
//  SPI_SCK   out  1  serial clock to OSD
//  SPI_SS3   out  1  OSD select, active low
//  SPI_DI    out  1  serial data to OSD (MOSI)
// BEHAVIOUR
//  Single clock; outputs registered; reset: SCK=0, SS3=1, DI=0, tx_ready=0, busy=0,
//   state=IDLE, counters 0; async reset mid-frame aborts at once, byte is lost.
//  accept = tx_valid & tx_ready at a clk_sys edge; tx_data/tx_last captured then.
//  tx_ready: registered; 1 in IDLE and WAIT; clears on accept edge; first 1 one
//   cycle after reset release; 0 in SHIFT, HOLD and GAP.
//  States:
//   IDLE : SS3=1, SCK=0. accept -> SHIFT; same edge SS3<=0, DI<=tx_data[7], bit=7.
//   SHIFT: per bit: CLK_DIV cycles SCK=0 then CLK_DIV cycles SCK=1. DI changes only
//          on SCK fall (and on entry), so DI is stable >=CLK_DIV cycles before
//          and after each rise. Byte = 16*CLK_DIV cycles. After bit 0 high
//          phase, SCK<=0 and: last latched -> HOLD, else -> WAIT.
//   WAIT : SS3=0, SCK=0, DI holds, tx_ready=1; stalls indefinitely.
//          accept -> SHIFT (DI<=tx_data[7]). No timeout.
//   HOLD : CLK_DIV cycles SCK=0, SS3=0, then SS3<=1 -> GAP.
//   GAP  : SS3=1 for GAP_CYCLES cycles -> IDLE.
//  Back-to-back bytes: min one WAIT cycle between bytes; SS3 held low whole frame.
//  tx_valid/tx_data changes while tx_ready=0 are ignored.
//  Div counter: clog2(CLK_DIV)+1 bits, wraps at CLK_DIV-1. Bit counter: 3 bits,
//   down-counts 7..0. Gap counter sized for GAP_CYCLES.
//  busy=1 from accept edge in IDLE through last GAP cycle.
// TESTING
//  1 CLK_DIV=2: byte 0x41, last=1 -> SS3 low 34 cycles; 8 SCK rises 4 cycles apart;
//    DI at rises 0,1,0,0,0,0,0,1; SS3 high >=4 cycles; busy then 0, tx_ready 1.
//  2 Frame 0x23 + 256 bytes 0x00..0xFF, valid always high -> SS3 low throughout,
//    2056 rises, OSD model reads cmd 0x23 and all 256 bytes in order.
//  3 Drop tx_valid 50 cycles after byte 2 -> SCK=0, SS3=0, DI steady 50+ cycles;
//    resume -> byte 3 correct, no extra SCK edges.
//  4 Frames 0x41 then 0x40 back to back -> SS3 high >= GAP_CYCLES between;
//    second accept only after GAP.
//  5 Assert reset mid-byte (bit 4 high phase) -> same cycle SCK=0, SS3=1,
//    tx_ready=0; after release, new frame 0x20 sent intact.
//  6 CLK_DIV=1, GAP_CYCLES=1: byte 0xA5 -> SCK toggles every cycle, DI 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/osd_spi_master.sv
// Transmit end of the OSD SPI link: mode 0, MSB first, SS3 held low for a whole
// tx_last-terminated frame, and a minimum deselect gap between frames.
module osd_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI,
    output logic [2:0] dbg_state
);

    // Handshake: a byte is accepted on a clk_sys edge where tx_valid and tx_ready are
    // both high; tx_data/tx_last are sampled only on that edge and ignored otherwise.

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [DW-1:0]   r_div;
    logic [DW-1:0]   w_div_nxt;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_nxt;
    logic [GW-1:0]   r_gap;
    logic [GW-1:0]   w_gap_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic            r_sck;
    logic            w_sck_nxt;
    logic            r_ss3;
    logic            w_ss3_nxt;
    logic            r_di;
    logic            w_di_nxt;
    logic            r_tx_ready;
    logic            w_tx_ready_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    logic            w_accept;
    logic            w_div_end;
    logic            w_gap_end;
    logic            w_byte_end;

    assign w_accept   = tx_valid & r_tx_ready;
    assign w_div_end  = (r_div == DIV_MAX);
    assign w_gap_end  = (r_gap == GAP_MAX);
    assign w_byte_end = w_div_end & r_sck & (r_bit == 3'd0);

    // State and registered outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_shift    <= '0;
            r_last     <= 1'b0;
            r_sck      <= 1'b0;
            r_ss3      <= 1'b1;
            r_di       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_gap      <= w_gap_nxt;
            r_shift    <= w_shift_nxt;
            r_last     <= w_last_nxt;
            r_sck      <= w_sck_nxt;
            r_ss3      <= w_ss3_nxt;
            r_di       <= w_di_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_byte_end) w_next_state = r_last ? ST_HOLD : ST_WAIT;
            ST_WAIT:  if (w_accept) w_next_state = ST_SHIFT;
            ST_HOLD:  if (w_div_end) w_next_state = ST_GAP;
            ST_GAP:   if (w_gap_end) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_div_nxt      = r_div;
        w_bit_nxt      = r_bit;
        w_gap_nxt      = r_gap;
        w_shift_nxt    = r_shift;
        w_last_nxt     = r_last;
        w_sck_nxt      = r_sck;
        w_ss3_nxt      = r_ss3;
        w_di_nxt       = r_di;
        w_tx_ready_nxt = r_tx_ready;
        w_busy_nxt     = (w_next_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                w_tx_ready_nxt = 1'b1;
                w_sck_nxt      = 1'b0;
                w_ss3_nxt      = 1'b1;
            end
            ST_SHIFT: begin
                // DI only moves on the falling edge, so it is stable around each rise
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                    end else begin
                        w_sck_nxt = 1'b0;
                        if (r_bit == 3'd0) begin
                            w_tx_ready_nxt = !r_last;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                            w_di_nxt  = r_shift[r_bit - 3'd1];
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            ST_WAIT: begin
                w_tx_ready_nxt = 1'b1;
                w_sck_nxt      = 1'b0;
            end
            ST_HOLD: begin
                if (w_div_end) begin
                    w_ss3_nxt = 1'b1;
                    w_div_nxt = '0;
                    w_gap_nxt = '0;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_tx_ready_nxt = 1'b1;
                    w_gap_nxt      = '0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_tx_ready_nxt = 1'b0;
            end
        endcase

        // Accept only ever happens in IDLE or WAIT, where tx_ready is high
        if (w_accept) begin
            w_tx_ready_nxt = 1'b0;
            w_ss3_nxt      = 1'b0;
            w_sck_nxt      = 1'b0;
            w_di_nxt       = tx_data[7];
            w_bit_nxt      = 3'd7;
            w_div_nxt      = '0;
            w_shift_nxt    = tx_data;
            w_last_nxt     = tx_last;
        end
    end

    assign tx_ready  = r_tx_ready;
    assign busy      = r_busy;
    assign SPI_SCK   = r_sck;
    assign SPI_SS3   = r_ss3;
    assign SPI_DI    = r_di;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_osd_spi_master.sv
// Directed bench for osd_spi_master: one instance at CLK_DIV=2/GAP=4, one at
// CLK_DIV=1/GAP=1, each watched by a small OSD receiver model.
module tb_osd_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] tx_data1 = 8'h00;
    logic       tx_last1 = 1'b0;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, busy1, sck1, ss3_1, di1;
    logic [2:0] st1;

    logic [7:0] tx_data2 = 8'h00;
    logic       tx_last2 = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, busy2, sck2, ss3_2, di2;
    logic [2:0] st2;

    int errors = 0;
    int checks = 0;

    time  rise_t1[$];
    logic bits1[$];
    time  setup1[$];
    time  di_chg1 = 0;
    int   ss3_rise1 = 0;
    time  rise_t2[$];
    logic bits2[$];
    time  setup2[$];
    time  di_chg2 = 0;
    longint cyc = 0;

    osd_spi_master #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut1 (
        .clk_sys(clk), .reset(rst), .tx_data(tx_data1), .tx_last(tx_last1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .SPI_SCK(sck1),
        .SPI_SS3(ss3_1), .SPI_DI(di1), .dbg_state(st1)
    );

    osd_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut2 (
        .clk_sys(clk), .reset(rst), .tx_data(tx_data2), .tx_last(tx_last2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .SPI_SCK(sck2),
        .SPI_SS3(ss3_2), .SPI_DI(di2), .dbg_state(st2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // OSD receiver models: sample DI on SCK rise while selected
    always @(di1) di_chg1 = $time;
    always @(di2) di_chg2 = $time;
    always @(posedge ss3_1) ss3_rise1++;
    always @(posedge sck1) begin
        if (ss3_1 === 1'b0) begin
            rise_t1.push_back($time);
            bits1.push_back(di1);
            setup1.push_back($time - di_chg1);
        end
    end
    always @(posedge sck2) begin
        if (ss3_2 === 1'b0) begin
            rise_t2.push_back($time);
            bits2.push_back(di2);
            setup2.push_back($time - di_chg2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic q[$], input int idx);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], (idx + i < q.size()) ? q[idx + i] : 1'bx};
        return b;
    endfunction

    function automatic int bad_spacing(input time q[$], input int from, input int n, input time want);
        int bad = 0;
        for (int i = from; i < from + n - 1; i++) begin
            if (i + 1 >= q.size() || q[i + 1] - q[i] != want) bad++;
        end
        return bad;
    endfunction

    function automatic int bad_setup(input time q[$], input int from, input int n, input time min_t);
        int bad = 0;
        for (int i = from; i < from + n; i++) begin
            if (i >= q.size() || q[i] < min_t) bad++;
        end
        return bad;
    endfunction

    // Presents a byte to dut1 and returns just after the edge that accepts it
    task automatic send_byte1(input logic [7:0] d, input logic l);
        int n = 0;
        tx_valid1 = 1'b1;
        tx_data1  = d;
        tx_last1  = l;
        while (tx_ready1 !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) check("accept_timeout", tx_ready1, 1);
        tick();
    endtask

    task automatic wait_ss3_high1(output int n);
        n = 0;
        while (ss3_1 === 1'b0 && n < 20000) begin
            n++;
            tick();
        end
        if (n >= 20000) check("ss3_timeout", ss3_1, 1);
    endtask

    task automatic wait_idle1(output int n);
        n = 0;
        while (busy1 !== 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        if (n >= 1000) check("idle_timeout", busy1, 0);
    endtask

    initial begin
        int n;
        int s;
        int r0;
        int bad;
        int q0;
        longint c0;
        longint c1;

        // Reset values
        rst = 1'b1;
        tick();
        check("rst_sck", sck1, 0);
        check("rst_ss3", ss3_1, 1);
        check("rst_di", di1, 0);
        check("rst_ready", tx_ready1, 0);
        check("rst_busy", busy1, 0);
        tick();
        rst = 1'b0;
        check("ready_at_release", tx_ready1, 0);
        tick();
        check("ready_after_release", tx_ready1, 1);
        check("idle_busy", busy1, 0);

        // 1: single byte 0x41
        s = bits1.size();
        send_byte1(8'h41, 1'b1);
        tx_valid1 = 1'b0;
        check("t1_busy_on_accept", busy1, 1);
        check("t1_ready_on_accept", tx_ready1, 0);
        check("t1_ss3_on_accept", ss3_1, 0);
        wait_ss3_high1(n);
        check("t1_ss3_low_cycles", n, 34);
        wait_idle1(n);
        check("t1_gap_cycles", n, 4);
        check("t1_ready_after", tx_ready1, 1);
        check("t1_rises", bits1.size() - s, 8);
        check("t1_byte", get_byte(bits1, s), 8'h41);
        check("t1_rise_spacing", bad_spacing(rise_t1, s, 8, 40), 0);
        check("t1_di_setup", bad_setup(setup1, s, 8, 20), 0);

        // 2: cmd 0x23 then 256 data bytes, valid kept high
        s  = bits1.size();
        r0 = ss3_rise1;
        send_byte1(8'h23, 1'b0);
        c0 = cyc;
        for (int k = 0; k < 256; k++) send_byte1(8'(k), (k == 255));
        c1 = cyc;
        tx_valid1 = 1'b0;
        wait_ss3_high1(n);
        check("t2_accept_spacing", 32'(c1 - c0), 256 * 33);
        check("t2_ss3_rises", ss3_rise1 - r0, 1);
        check("t2_rises", bits1.size() - s, 2056);
        check("t2_cmd", get_byte(bits1, s), 8'h23);
        bad = 0;
        for (int k = 0; k < 256; k++) if (get_byte(bits1, s + 8 * (k + 1)) !== 8'(k)) bad++;
        check("t2_data_bytes", bad, 0);
        check("t2_di_setup", bad_setup(setup1, s, 2056, 20), 0);
        wait_idle1(n);

        // 3: stall in WAIT after byte 2
        s  = bits1.size();
        r0 = ss3_rise1;
        send_byte1(8'h20, 1'b0);
        send_byte1(8'h5A, 1'b0);
        send_byte1(8'hC3, 1'b0);
        tx_valid1 = 1'b0;
        n = 0;
        while (tx_ready1 !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        q0  = bits1.size();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (sck1 !== 1'b0 || ss3_1 !== 1'b0 || di1 !== 1'b1 || tx_ready1 !== 1'b1) bad++;
            tick();
        end
        check("t3_stall_steady", bad, 0);
        check("t3_no_extra_rises", bits1.size() - q0, 0);
        send_byte1(8'h96, 1'b1);
        tx_valid1 = 1'b0;
        wait_ss3_high1(n);
        check("t3_ss3_rises", ss3_rise1 - r0, 1);
        check("t3_rises", bits1.size() - s, 32);
        check("t3_byte0", get_byte(bits1, s), 8'h20);
        check("t3_byte1", get_byte(bits1, s + 8), 8'h5A);
        check("t3_byte2", get_byte(bits1, s + 16), 8'hC3);
        check("t3_byte3", get_byte(bits1, s + 24), 8'h96);
        wait_idle1(n);

        // 4: two one-byte frames back to back
        s = bits1.size();
        send_byte1(8'h41, 1'b1);
        tx_data1 = 8'h40;
        tx_last1 = 1'b1;
        wait_ss3_high1(n);
        n   = 0;
        bad = 0;
        while (ss3_1 === 1'b1 && n < 100) begin
            if (tx_ready1 === 1'b1) bad++;
            n++;
            tick();
        end
        check("t4_ss3_high_cycles", n, 5);
        check("t4_ready_in_gap", bad, 1);
        check("t4_busy_second", busy1, 1);
        tx_valid1 = 1'b0;
        wait_ss3_high1(n);
        check("t4_byte0", get_byte(bits1, s), 8'h41);
        check("t4_byte1", get_byte(bits1, s + 8), 8'h40);
        wait_idle1(n);

        // 5: reset during bit 4 high phase
        s = bits1.size();
        send_byte1(8'h33, 1'b1);
        tx_valid1 = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        check("t5_sck_high_bit4", sck1, 1);
        check("t5_rises_before", bits1.size() - s, 4);
        rst = 1'b1;
        #1;
        check("t5_rst_sck", sck1, 0);
        check("t5_rst_ss3", ss3_1, 1);
        check("t5_rst_ready", tx_ready1, 0);
        check("t5_rst_busy", busy1, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t5_ready_after", tx_ready1, 1);
        s = bits1.size();
        send_byte1(8'h20, 1'b1);
        tx_valid1 = 1'b0;
        wait_ss3_high1(n);
        check("t5_ss3_low_cycles", n, 34);
        check("t5_rises", bits1.size() - s, 8);
        check("t5_byte", get_byte(bits1, s), 8'h20);
        wait_idle1(n);

        // 6: CLK_DIV=1, GAP_CYCLES=1, byte 0xA5
        s = bits2.size();
        check("t6_ready", tx_ready2, 1);
        tx_valid2 = 1'b1;
        tx_data2  = 8'hA5;
        tx_last2  = 1'b1;
        tick();
        tx_valid2 = 1'b0;
        n = 0;
        while (ss3_2 === 1'b0 && n < 200) begin
            n++;
            tick();
        end
        check("t6_ss3_low_cycles", n, 17);
        n = 0;
        while (busy2 !== 1'b0 && n < 200) begin
            n++;
            tick();
        end
        check("t6_gap_cycles", n, 1);
        check("t6_ready_after", tx_ready2, 1);
        check("t6_rises", bits2.size() - s, 8);
        check("t6_byte", get_byte(bits2, s), 8'hA5);
        check("t6_rise_spacing", bad_spacing(rise_t2, s, 8, 20), 0);
        check("t6_di_setup", bad_setup(setup2, s, 8, 10), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
